// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_pkg
// Description : Code constants and symbol helpers for the K=3 rate-1/2 decoder
// Revision    : 1.0 - initial release
// ============================================================================
package viterbi_pkg;

    localparam int         K       = 3;
    localparam int         NSTATES = 2 ** (K - 1);
    localparam logic [2:0] G0      = 3'b111;
    localparam logic [2:0] G1      = 3'b101;

    // State is {b[t-1], b[t-2]}, so the generator taps line up with {b, state}.
    function automatic logic [1:0] exp_sym(input logic [1:0] state, input logic b);
        logic [2:0] w_taps;
        w_taps = {b, state};
        return {^(w_taps & G0), ^(w_taps & G1)};
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] w_diff;
        w_diff = a ^ b;
        return {1'b0, w_diff[1]} + {1'b0, w_diff[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/viterbi_acs.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_acs
// Description : Add-compare-select for one trellis state with register exchange
// Revision    : 1.0 - initial release
// ============================================================================
module viterbi_acs #(
    parameter int   PM_W     = 4,
    parameter int   TB_DEPTH = 16,
    parameter logic NEW_BIT  = 1'b0
) (
    input  logic [PM_W-1:0]     pm0,
    input  logic [PM_W-1:0]     pm1,
    input  logic [1:0]          bm0,
    input  logic [1:0]          bm1,
    input  logic [TB_DEPTH-2:0] surv0,
    input  logic [TB_DEPTH-2:0] surv1,
    output logic [PM_W-1:0]     pm_out,
    output logic                dec,
    output logic [TB_DEPTH-1:0] surv_out
);

    logic [PM_W:0]   w_sum0;
    logic [PM_W:0]   w_sum1;
    logic [PM_W-1:0] w_cand0;
    logic [PM_W-1:0] w_cand1;

    always_comb begin
        w_sum0  = {1'b0, pm0} + (PM_W + 1)'(bm0);
        w_sum1  = {1'b0, pm1} + (PM_W + 1)'(bm1);
        w_cand0 = w_sum0[PM_W] ? '1 : w_sum0[PM_W-1:0];
        w_cand1 = w_sum1[PM_W] ? '1 : w_sum1[PM_W-1:0];
    end

    // Strict compare: ties resolve to the even predecessor.
    assign dec      = (w_cand1 < w_cand0);
    assign pm_out   = dec ? w_cand1 : w_cand0;
    assign surv_out = {(dec ? surv1 : surv0), NEW_BIT};

endmodule
`default_nettype wire

// File: rtl/viterbi_decoder.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_decoder
// Description : Hard-decision 4-state Viterbi decoder, register-exchange survivors
// Revision    : 1.0 - initial release
// ============================================================================
module viterbi_decoder #(
    parameter int PM_W     = 4,
    parameter int TB_DEPTH = 16
) (
    input  logic            ck,
    input  logic            rset,
    input  logic [1:0]      cin,
    input  logic            cin_valid,
    output logic            bout,
    output logic            bout_valid,
    output logic [PM_W-1:0] pm_best
);

    import viterbi_pkg::*;

    localparam int              c_cnt_w    = $clog2(TB_DEPTH + 1);
    localparam logic [PM_W-1:0] c_pm_max   = '1;
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(TB_DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TB_DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    // The oldest survivor bit is consumed on the edge it would be shifted out,
    // so only TB_DEPTH-1 bits per state are kept in registers.
    logic [PM_W-1:0]     r_pm       [NSTATES];
    logic [TB_DEPTH-2:0] r_surv     [NSTATES];
    logic [c_cnt_w-1:0]  r_cnt;

    logic [PM_W-1:0]     w_new_pm   [NSTATES];
    logic [TB_DEPTH-1:0] w_new_surv [NSTATES];
    logic [NSTATES-1:0]  w_unused_dec;
    logic [PM_W-1:0]     w_min;
    logic [1:0]          w_best;

    for (genvar gi = 0; gi < NSTATES; gi++) begin : g_acs
        localparam logic [1:0] c_ns = 2'(gi);
        localparam logic [1:0] c_p0 = {c_ns[0], 1'b0};
        localparam logic [1:0] c_p1 = {c_ns[0], 1'b1};

        viterbi_acs #(
            .PM_W     (PM_W),
            .TB_DEPTH (TB_DEPTH),
            .NEW_BIT  (c_ns[1])
        ) u_acs (
            .pm0      (r_pm[c_p0]),
            .pm1      (r_pm[c_p1]),
            .bm0      (hamming2(cin, exp_sym(c_p0, c_ns[1]))),
            .bm1      (hamming2(cin, exp_sym(c_p1, c_ns[1]))),
            .surv0    (r_surv[c_p0]),
            .surv1    (r_surv[c_p1]),
            .pm_out   (w_new_pm[gi]),
            .dec      (w_unused_dec[gi]),
            .surv_out (w_new_surv[gi])
        );
    end

    // Lowest index wins ties thanks to the strict compare.
    always_comb begin
        w_min  = w_new_pm[0];
        w_best = 2'd0;
        for (int i = 1; i < NSTATES; i++) begin
            if (w_new_pm[i] < w_min) begin
                w_min  = w_new_pm[i];
                w_best = 2'(i);
            end
        end
    end

    always_ff @(posedge ck) begin
        if (!rset) begin
            for (int i = 0; i < NSTATES; i++) begin
                r_pm[i]   <= (i == 0) ? '0 : c_pm_max;
                r_surv[i] <= '0;
            end
            r_cnt      <= '0;
            bout       <= 1'b0;
            bout_valid <= 1'b0;
            pm_best    <= '0;
        end else if (cin_valid) begin
            for (int i = 0; i < NSTATES; i++) begin
                r_pm[i]   <= (w_new_pm[i] == c_pm_max) ? c_pm_max : w_new_pm[i] - w_min;
                r_surv[i] <= w_new_surv[i][TB_DEPTH-2:0];
            end
            if (r_cnt != c_cnt_full) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
            bout       <= w_new_surv[w_best][TB_DEPTH-1];
            bout_valid <= (r_cnt >= c_cnt_last);
            // Stored metrics are normalized to a zero minimum, so m is the growth.
            pm_best    <= w_min;
        end else begin
            bout_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_viterbi_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_viterbi_decoder
// Description : Scoreboard bench for viterbi_decoder with directed and soak streams
// Revision    : 1.0 - initial release
// ============================================================================
module tb_viterbi_decoder;

    localparam int PM_W     = 4;
    localparam int TB_DEPTH = 16;
    localparam int NDIR     = 24;
    localparam int NSOAK    = 2000;

    logic            ck        = 1'b0;
    logic            rset      = 1'b0;
    logic [1:0]      cin       = 2'b00;
    logic            cin_valid = 1'b0;
    logic            bout;
    logic            bout_valid;
    logic [PM_W-1:0] pm_best;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    int sym_cnt  = 0;
    bit sbq[$];

    // Hand-encoded 1,0,1,1 followed by twenty zeros (24 symbols kept).
    logic [1:0] dir_sym [NDIR] = '{0: 2'b11, 1: 2'b10, 2: 2'b00, 3: 2'b01,
                                   4: 2'b01, 5: 2'b11, default: 2'b00};
    bit         dir_bit [NDIR] = '{0: 1'b1, 1: 1'b0, 2: 1'b1, 3: 1'b1, default: 1'b0};

    viterbi_decoder #(
        .PM_W     (PM_W),
        .TB_DEPTH (TB_DEPTH)
    ) dut (
        .ck         (ck),
        .rset       (rset),
        .cin        (cin),
        .cin_valid  (cin_valid),
        .bout       (bout),
        .bout_valid (bout_valid),
        .pm_best    (pm_best)
    );

    always #5 ck = ~ck;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every decoded bit is matched against the oldest queued source bit.
    always @(negedge ck) begin
        if (bout_valid === 1'b1) begin
            n_out++;
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL bout_unexpected: got %0d, expected no output", bout);
            end else begin
                check("bout", int'(bout), int'(sbq.pop_front()));
            end
        end
    end

    function automatic logic [1:0] enc(input logic [1:0] s, input bit b);
        return {b ^ s[1] ^ s[0], b ^ s[0]};
    endfunction

    task automatic do_reset(input int ncyc);
        @(negedge ck);
        rset      = 1'b0;
        cin_valid = 1'b1;
        cin       = 2'b11;
        repeat (ncyc) begin
            @(posedge ck);
            #1;
            check("rst_bout", int'(bout), 0);
            check("rst_bout_valid", int'(bout_valid), 0);
            check("rst_pm_best", int'(pm_best), 0);
        end
        @(negedge ck);
        rset      = 1'b1;
        cin_valid = 1'b0;
        sbq.delete();
        sym_cnt = 0;
        n_out   = 0;
    endtask

    // exp_pm < 0 means only the bound pm_best <= 1 is checked.
    task automatic send(input logic [1:0] sym, input bit src, input int exp_pm);
        @(negedge ck);
        cin       = sym;
        cin_valid = 1'b1;
        @(posedge ck);
        sbq.push_back(src);
        sym_cnt++;
        #1;
        cin_valid = 1'b0;
        check("bout_valid", int'(bout_valid), (sym_cnt >= TB_DEPTH) ? 1 : 0);
        if (exp_pm >= 0) begin
            check("pm_best", int'(pm_best), exp_pm);
        end else begin
            n_checks++;
            if (pm_best > 1) begin
                n_fail++;
                $display("FAIL pm_best_bound: got %0d, required <= 1", pm_best);
            end
        end
    endtask

    task automatic idle(input int ncyc);
        logic            held_bout;
        logic [PM_W-1:0] held_pm;
        held_bout = bout;
        held_pm   = pm_best;
        repeat (ncyc) begin
            @(negedge ck);
            cin       = 2'($urandom_range(0, 3));
            cin_valid = 1'b0;
            @(posedge ck);
            #1;
            check("gap_bout_valid", int'(bout_valid), 0);
            check("gap_bout_hold", int'(bout), int'(held_bout));
            check("gap_pm_hold", int'(pm_best), int'(held_pm));
        end
    endtask

    task automatic run_dir(input int nsym, input int bad, input int gap);
        for (int i = 0; i < nsym; i++) begin
            logic [1:0] s;
            s = dir_sym[i];
            if (i == bad) s = s ^ 2'b10;
            send(s, dir_bit[i], (i == bad) ? 1 : 0);
            if (gap > 0 && i < nsym - 1) idle(gap);
        end
        @(negedge ck);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] st;
        logic [1:0] sym;
        bit         b;
        int         last_err;

        // Reset held with valid symbols present; reset must win.
        do_reset(2);

        run_dir(NDIR, -1, 0);
        check("clean_out_count", n_out, NDIR - TB_DEPTH + 1);

        do_reset(1);
        run_dir(NDIR, 1, 0);
        check("err_out_count", n_out, NDIR - TB_DEPTH + 1);

        do_reset(1);
        run_dir(NDIR, -1, 3);
        check("gap_out_count", n_out, NDIR - TB_DEPTH + 1);

        // Mid-stream reset discards history, then a fresh stream decodes.
        do_reset(1);
        run_dir(10, -1, 0);
        do_reset(1);
        run_dir(NDIR, -1, 0);
        check("restart_out_count", n_out, NDIR - TB_DEPTH + 1);

        // Soak: random data, single-bit errors at least six symbols apart.
        do_reset(1);
        st       = 2'b00;
        last_err = -100;
        for (int i = 0; i < NSOAK; i++) begin
            b   = 1'($urandom_range(0, 1));
            sym = enc(st, b);
            st  = {b, st[1]};
            if (i - last_err >= 6 && $urandom_range(0, 3) == 0) begin
                sym      = sym ^ (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
                last_err = i;
            end
            send(sym, b, -1);
        end
        @(negedge ck);
        #1;
        check("soak_out_count", n_out, NSOAK - TB_DEPTH + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
